ivs_mem_arb: RTL and testbench

IVS_MEM_ARB -- requirements
Module: ivs_mem_arb

---
 rtl/ivs_mem_arb.sv | 150 +++++++++++++++
 tb/tb_ivs_mem_arb.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ivs_mem_arb.sv
// Two-requester arbiter for a single-port RAM: zero-cycle grant, round-robin with burst limit.
// Optional grant statistics are built when IVS_MEM_ARB_STAT_EN is defined.
module ivs_mem_arb #(
  parameter int DW        = 32,
  parameter int AW        = 6,
  parameter int MAX_BURST = 4
) (
  input  logic          hclk,
  input  logic          hrst_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  output logic          mem_rd,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [15:0]   stat_cnt0,
  output logic [15:0]   stat_cnt1
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_nextState;
  logic [1:0]    r_ptr;
  logic [BW-1:0] r_burst;
  logic          r_rdPend0;
  logic          r_rdPend1;
  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_burstFull;

  assign w_burstFull = (r_burst == BURST_MAX);

  // The owner yields only when its burst is exhausted and the other side waits.
  always_comb begin
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_nextState = ST_IDLE;
    case (r_state)
      ST_IDLE: begin
        if (req0 && req1) begin
          if (r_ptr == 2'd0) w_gnt1 = 1'b1;
          else               w_gnt0 = 1'b1;
        end else begin
          w_gnt0 = req0;
          w_gnt1 = req1;
        end
      end
      ST_OWN0: begin
        if (req0 && !(req1 && w_burstFull)) w_gnt0 = 1'b1;
        else                                w_gnt1 = req1;
      end
      ST_OWN1: begin
        if (req1 && !(req0 && w_burstFull)) w_gnt1 = 1'b1;
        else                                w_gnt0 = req0;
      end
      default: begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
      end
    endcase
    if (!hrst_n) begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end
    if (w_gnt0)      w_nextState = ST_OWN0;
    else if (w_gnt1) w_nextState = ST_OWN1;
    else             w_nextState = ST_IDLE;
  end

  always_ff @(posedge hclk) begin
    if (!hrst_n) begin
      r_state   <= ST_IDLE;
      r_ptr     <= 2'd1;
      r_burst   <= '0;
      r_rdPend0 <= 1'b0;
      r_rdPend1 <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_rdPend0 <= w_gnt0 & ~we0;
      r_rdPend1 <= w_gnt1 & ~we1;
      if (w_gnt0) begin
        r_ptr   <= 2'd0;
        r_burst <= (r_state != ST_OWN0) ? BW'(1) :
                   (w_burstFull ? r_burst : r_burst + 1'b1);
      end else if (w_gnt1) begin
        r_ptr   <= 2'd1;
        r_burst <= (r_state != ST_OWN1) ? BW'(1) :
                   (w_burstFull ? r_burst : r_burst + 1'b1);
      end else begin
        r_burst <= '0;
      end
    end
  end

  assign gnt0      = w_gnt0;
  assign gnt1      = w_gnt1;
  assign mem_rd    = (w_gnt0 & ~we0) | (w_gnt1 & ~we1);
  assign mem_we    = (w_gnt0 & we0) | (w_gnt1 & we1);
  assign mem_addr  = w_gnt0 ? addr0 : (w_gnt1 ? addr1 : '0);
  assign mem_wdata = w_gnt0 ? wdata0 : (w_gnt1 ? wdata1 : '0);

  // Gating with reset hides a return that was in flight when reset arrived.
  assign rvalid0 = r_rdPend0 & hrst_n;
  assign rvalid1 = r_rdPend1 & hrst_n;
  assign rdata0  = rvalid0 ? mem_rdata : '0;
  assign rdata1  = rvalid1 ? mem_rdata : '0;

`ifdef IVS_MEM_ARB_STAT_EN
  logic [15:0] r_statCnt0;
  logic [15:0] r_statCnt1;

  always_ff @(posedge hclk) begin
    if (!hrst_n) begin
      r_statCnt0 <= '0;
      r_statCnt1 <= '0;
    end else begin
      if (w_gnt0 && (r_statCnt0 != 16'hFFFF)) r_statCnt0 <= r_statCnt0 + 16'd1;
      if (w_gnt1 && (r_statCnt1 != 16'hFFFF)) r_statCnt1 <= r_statCnt1 + 16'd1;
    end
  end

  assign stat_cnt0 = r_statCnt0;
  assign stat_cnt1 = r_statCnt1;
`else
  assign stat_cnt0 = 16'd0;
  assign stat_cnt1 = 16'd0;
`endif

endmodule

// File: tb/tb_ivs_mem_arb.sv
// Self-checking bench for ivs_mem_arb: directed scenarios plus randomized traffic
// compared against an ownership/burst-count model and a shadow copy of the RAM.
module tb_ivs_mem_arb;

  localparam int DW        = 32;
  localparam int AW        = 6;
  localparam int MAX_BURST = 4;
`ifdef IVS_MEM_ARB_STAT_EN
  localparam bit STAT_EN = 1'b1;
`else
  localparam bit STAT_EN = 1'b0;
`endif

  logic          hclk;
  logic          hrstN;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic          memRd, memWe;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memWdata, memRdata;
  logic [15:0]   statCnt0, statCnt1;

  int checkCount = 0;
  int passCount  = 0;

  ivs_mem_arb #(.DW(DW), .AW(AW), .MAX_BURST(MAX_BURST)) dut (
    .hclk(hclk), .hrst_n(hrstN),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_rd(memRd), .mem_we(memWe), .mem_addr(memAddr),
    .mem_wdata(memWdata), .mem_rdata(memRdata),
    .stat_cnt0(statCnt0), .stat_cnt1(statCnt1)
  );

  // Free-running 10-unit clock
  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  // Behavioural single-port RAM with one-cycle read latency
  logic [DW-1:0] ram [64];
  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 32'hA5A5_0000 | DW'(i);
    memRdata = '0;
    forever begin
      @(posedge hclk);
      if (memWe) ram[memAddr] <= memWdata;
      if (memRd) memRdata <= ram[memAddr];
    end
  end

  // Reference model state: who currently owns the RAM, how many grants in a row,
  // who was served last, outstanding reads and an independent copy of RAM contents
  int            modelOwner;
  int            modelLast;
  int            modelBurst;
  bit            pend0, pend1;
  logic [DW-1:0] pendData0, pendData1;
  logic [DW-1:0] shadow [64];
  int            statModel0, statModel1;
  bit            expG0, expG1;
  bit            obsGnt0, obsGnt1, obsRvalid0;
  logic [DW-1:0] obsRdata0;
  logic [15:0]   obsStat0, obsStat1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
  endtask

  // Decide the winner from the arbitration rules: lone request wins, contention
  // from idle goes to whoever was not served last, an owner keeps the RAM until it
  // has used MAX_BURST grants while the other waits or until it stops asking.
  function automatic int modelWinner(input bit r0, input bit r1);
    bit ownReq, othReq;
    if (modelOwner < 0) begin
      if (r0 && r1) return 1 - modelLast;
      if (r0) return 0;
      if (r1) return 1;
      return -1;
    end
    ownReq = (modelOwner == 0) ? r0 : r1;
    othReq = (modelOwner == 0) ? r1 : r0;
    if (ownReq && !(othReq && modelBurst >= MAX_BURST)) return modelOwner;
    if (othReq) return 1 - modelOwner;
    return -1;
  endfunction

  task automatic modelReset();
    modelOwner = -1;
    modelLast  = 1;
    modelBurst = 0;
    pend0      = 1'b0;
    pend1      = 1'b0;
    statModel0 = 0;
    statModel1 = 0;
  endtask

  // One clock cycle: drive after the falling edge, check combinational and
  // registered outputs, then advance the model to match the coming rising edge.
  task automatic applyStimulus(input bit rstN,
                               input bit r0, input bit w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                               input bit r1, input bit w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    int            win;
    logic [AW-1:0] expAddr;
    logic [DW-1:0] expWdata;
    bit            expRv0, expRv1;
    @(negedge hclk);
    hrstN = rstN;
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    #1;
    win   = rstN ? modelWinner(r0, r1) : -1;
    expG0 = (win == 0);
    expG1 = (win == 1);
    expAddr  = expG0 ? a0 : (expG1 ? a1 : '0);
    expWdata = expG0 ? d0 : (expG1 ? d1 : '0);
    expRv0 = pend0 && rstN;
    expRv1 = pend1 && rstN;
    checkOutput("gnt0", 32'(gnt0), 32'(expG0));
    checkOutput("gnt1", 32'(gnt1), 32'(expG1));
    checkOutput("mem_rd", 32'(memRd), 32'((expG0 && !w0) || (expG1 && !w1)));
    checkOutput("mem_we", 32'(memWe), 32'((expG0 && w0) || (expG1 && w1)));
    checkOutput("mem_addr", 32'(memAddr), 32'(expAddr));
    checkOutput("mem_wdata", memWdata, expWdata);
    checkOutput("rvalid0", 32'(rvalid0), 32'(expRv0));
    checkOutput("rdata0", rdata0, expRv0 ? pendData0 : 32'd0);
    checkOutput("rvalid1", 32'(rvalid1), 32'(expRv1));
    checkOutput("rdata1", rdata1, expRv1 ? pendData1 : 32'd0);
    checkOutput("stat_cnt0", 32'(statCnt0), STAT_EN ? 32'(statModel0) : 32'd0);
    checkOutput("stat_cnt1", 32'(statCnt1), STAT_EN ? 32'(statModel1) : 32'd0);
    obsGnt0 = gnt0; obsGnt1 = gnt1; obsRvalid0 = rvalid0; obsRdata0 = rdata0;
    obsStat0 = statCnt0; obsStat1 = statCnt1;
    if (!rstN) begin
      modelReset();
    end else begin
      pend0 = expG0 && !w0;
      pend1 = expG1 && !w1;
      pendData0 = shadow[a0];
      pendData1 = shadow[a1];
      if (win >= 0) begin
        modelBurst = (win == modelOwner) ? ((modelBurst < MAX_BURST) ? modelBurst + 1 : MAX_BURST) : 1;
        modelOwner = win;
        modelLast  = win;
      end else begin
        modelOwner = -1;
        modelBurst = 0;
      end
      if (expG0) begin
        if (w0) shadow[a0] = d0;
        if (statModel0 < 16'hFFFF) statModel0++;
      end
      if (expG1) begin
        if (w1) shadow[a1] = d1;
        if (statModel1 < 16'hFFFF) statModel1++;
      end
    end
  endtask

  task automatic idleCycle(input bit rstN);
    applyStimulus(rstN, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  logic [11:0]   pat0, pat1;
  bit            act0, act1, rwe0, rwe1, rstRand;
  logic [AW-1:0] radr0, radr1;
  logic [DW-1:0] rdat0, rdat1;

  initial begin
    for (int i = 0; i < 64; i++) shadow[i] = 32'hA5A5_0000 | DW'(i);
    modelReset();
    hrstN = 1'b0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    repeat (2) @(negedge hclk);
    idleCycle(1'b0);
    // Reset forces grants and strobes low even with both requests up
    applyStimulus(1'b0, 1'b1, 1'b0, 6'd1, '0, 1'b1, 1'b1, 6'd2, 32'h55);

    // Lone read at address 5
    applyStimulus(1'b1, 1'b1, 1'b0, 6'd5, '0, 1'b0, 1'b0, '0, '0);
    checkOutput("lone_gnt0", 32'(obsGnt0), 32'd1);
    idleCycle(1'b1);
    checkOutput("lone_rvalid0", 32'(obsRvalid0), 32'd1);
    checkOutput("lone_rdata0", obsRdata0, 32'hA5A5_0005);

    // Continuous contention straight out of reset
    idleCycle(1'b0);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, AW'(i), '0, 1'b1, 1'b0, AW'(i + 16), '0);
      pat0[11 - i] = obsGnt0;
      pat1[11 - i] = obsGnt1;
    end
    checkOutput("burst_pattern_gnt0", 32'(pat0), 32'h0F0F);
    checkOutput("burst_pattern_gnt1", 32'(pat1), 32'h00F0);
    idleCycle(1'b1);

    // Write by requester 1, read back by requester 0
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 6'd9, 32'h1234);
    applyStimulus(1'b1, 1'b1, 1'b0, 6'd9, '0, 1'b0, 1'b0, '0, '0);
    idleCycle(1'b1);
    checkOutput("wr_rd_rdata0", obsRdata0, 32'h1234);

    // Owner drops its request with requester 1 waiting
    idleCycle(1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 6'd1, '0, 1'b0, 1'b0, '0, '0);
    applyStimulus(1'b1, 1'b1, 1'b0, 6'd2, '0, 1'b1, 1'b0, 6'd3, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 6'd3, '0);
    checkOutput("handoff_gnt1", 32'(obsGnt1), 32'd1);
    idleCycle(1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 6'd4, '0, 1'b1, 1'b0, 6'd6, '0);
    checkOutput("rr_favour_gnt0", 32'(obsGnt0), 32'd1);
    idleCycle(1'b1);

    // Reset right after a read grant, with requester 0 at full burst
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0, AW'(7), '0, 1'b0, 1'b0, '0, '0);
    idleCycle(1'b0);
    checkOutput("rst_rvalid0", 32'(obsRvalid0), 32'd0);
    idleCycle(1'b1);
    checkOutput("post_rst_rvalid0", 32'(obsRvalid0), 32'd0);
    checkOutput("post_rst_stat0", 32'(obsStat0), 32'd0);
    checkOutput("post_rst_stat1", 32'(obsStat1), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 6'd8, '0, 1'b1, 1'b0, 6'd10, '0);
    checkOutput("post_rst_gnt0", 32'(obsGnt0), 32'd1);
    idleCycle(1'b1);

    // Grant statistics: 10 grants to 0, then 3 to 1
    idleCycle(1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 1'b1, AW'(32 + i), DW'(i), 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, AW'(48 + i), DW'(100 + i));
    idleCycle(1'b1);
    checkOutput("stat_total0", 32'(obsStat0), STAT_EN ? 32'd10 : 32'd0);
    checkOutput("stat_total1", 32'(obsStat1), STAT_EN ? 32'd3 : 32'd0);

    // Randomized traffic: each requester holds a transaction until it is granted
    act0 = 1'b0; act1 = 1'b0;
    rwe0 = 1'b0; rwe1 = 1'b0; radr0 = '0; radr1 = '0; rdat0 = '0; rdat1 = '0;
    for (int c = 0; c < 600; c++) begin
      if (!act0 && $urandom_range(0, 99) < 70) begin
        act0 = 1'b1; rwe0 = 1'($urandom_range(0, 1)); radr0 = AW'($urandom_range(0, 7)); rdat0 = $urandom;
      end
      if (!act1 && $urandom_range(0, 99) < 70) begin
        act1 = 1'b1; rwe1 = 1'($urandom_range(0, 1)); radr1 = AW'($urandom_range(0, 7)); rdat1 = $urandom;
      end
      rstRand = ($urandom_range(0, 79) != 0);
      applyStimulus(rstRand, act0, rwe0, radr0, rdat0, act1, rwe1, radr1, rdat1);
      if (expG0) act0 = 1'b0;
      if (expG1) act1 = 1'b0;
    end
    idleCycle(1'b1);
    idleCycle(1'b1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
